// File: rtl/loom_init_dpi_pkg.sv
// Shared types and default widths for the boot-time DPI init-call sequencer.
package loom_init_dpi_pkg;

   localparam int unsigned DefNumCalls      = 2;
   localparam int unsigned DefFuncIdWidth   = 8;
   localparam int unsigned DefArgWidth      = 32;
   localparam int unsigned DefRetWidth      = 32;
   localparam int unsigned DefTimeoutCycles = 1024;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWait,
      StInject,
      StAdvance,
      StDone,
      StError
   } state_e;

   typedef struct packed {
      logic [DefFuncIdWidth-1:0] func_id;
      logic [DefArgWidth-1:0]    arg;
   } call_slot_t;

   // Index width never collapses to zero bits, even for a single slot.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/loom_init_dpi_seq_if.sv
// Request/response handshake between the init sequencer (master) and the host DPI bridge (slave).
interface loom_init_dpi_seq_if
   import loom_init_dpi_pkg::*;
#(
   parameter int unsigned FuncIdWidth = DefFuncIdWidth,
   parameter int unsigned ArgWidth    = DefArgWidth,
   parameter int unsigned RetWidth    = DefRetWidth
);

   logic                   req_valid_o;
   logic                   req_ready_i;
   logic [FuncIdWidth-1:0] req_func_id_o;
   logic [ArgWidth-1:0]    req_arg_o;
   logic                   rsp_valid_i;
   logic [RetWidth-1:0]    rsp_data_i;
   logic                   rsp_ready_o;

   modport master (
      output req_valid_o,
      output req_func_id_o,
      output req_arg_o,
      output rsp_ready_o,
      input  req_ready_i,
      input  rsp_valid_i,
      input  rsp_data_i
   );

   modport slave (
      input  req_valid_o,
      input  req_func_id_o,
      input  req_arg_o,
      input  rsp_ready_o,
      output req_ready_i,
      output rsp_valid_i,
      output rsp_data_i
   );

endinterface

// File: rtl/loom_init_dpi_seq.sv
// Issues init-phase DPI calls one at a time, injects returned values, then releases the DUT reset.
// Define LOOM_INIT_DPI_TIMEOUT_EN to enable the per-call WAIT timeout and the ERROR state.
module loom_init_dpi_seq
   import loom_init_dpi_pkg::*;
#(
   parameter int unsigned       NumCalls      = DefNumCalls,
   parameter int unsigned       FuncIdWidth   = DefFuncIdWidth,
   parameter int unsigned       ArgWidth      = DefArgWidth,
   parameter int unsigned       RetWidth      = DefRetWidth,
   parameter logic [NumCalls-1:0] VoidMask    = 2'b01,
   parameter int unsigned       TimeoutCycles = DefTimeoutCycles,
   localparam int unsigned      IdxWidth      = idx_width(NumCalls)
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            start_i,
   input  logic [NumCalls*FuncIdWidth-1:0] slot_func_id_i,
   input  logic [NumCalls*ArgWidth-1:0]    slot_arg_i,
   loom_init_dpi_seq_if.master             bus,
   output logic                            inj_valid_o,
   output logic [IdxWidth-1:0]             inj_idx_o,
   output logic [RetWidth-1:0]             inj_data_o,
   output logic                            dut_rst_no,
   output logic                            busy_o,
   output logic                            done_o,
   output logic                            error_o,
   output logic [IdxWidth-1:0]             err_idx_o
);

   state_e              state_q, state_d;
   logic [IdxWidth-1:0] idx_q, idx_d;
   logic [IdxWidth-1:0] inj_idx_q, inj_idx_d;
   logic [RetWidth-1:0] inj_data_q, inj_data_d;

   logic                is_last;
   logic                slot_is_void;

   assign is_last      = (idx_q == IdxWidth'(NumCalls - 1));
   assign slot_is_void = VoidMask[idx_q];

`ifdef LOOM_INIT_DPI_TIMEOUT_EN
   localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);

   logic [CntWidth-1:0] cnt_q;
   logic                cnt_clr;
   logic                cnt_inc;
   logic                cnt_at_limit;

   // One more silent WAIT cycle at this count reaches the limit.
   assign cnt_at_limit = (cnt_q == CntWidth'(TimeoutCycles - 1));

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (cnt_clr) begin
         cnt_q <= '0;
      end else if (cnt_inc) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         inj_idx_q  <= '0;
         inj_data_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         inj_idx_q  <= inj_idx_d;
         inj_data_q <= inj_data_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      inj_idx_d  = inj_idx_q;
      inj_data_d = inj_data_q;
`ifdef LOOM_INIT_DPI_TIMEOUT_EN
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StIssue;
               idx_d   = '0;
            end
         end
         StIssue: begin
            if (bus.req_ready_i) begin
               state_d = StWait;
`ifdef LOOM_INIT_DPI_TIMEOUT_EN
               cnt_clr = 1'b1;
`endif
            end
         end
         StWait: begin
            if (bus.rsp_valid_i) begin
               if (slot_is_void) begin
                  state_d = StAdvance;
               end else begin
                  // Load only for injecting slots so the inject outputs hold otherwise.
                  state_d    = StInject;
                  inj_idx_d  = idx_q;
                  inj_data_d = bus.rsp_data_i;
               end
`ifdef LOOM_INIT_DPI_TIMEOUT_EN
            end else if (cnt_at_limit) begin
               state_d = StError;
            end else begin
               cnt_inc = 1'b1;
`endif
            end
         end
         StInject: begin
            state_d = StAdvance;
         end
         StAdvance: begin
            if (is_last) begin
               state_d = StDone;
            end else begin
               state_d = StIssue;
               idx_d   = idx_q + 1'b1;
            end
         end
         StDone, StError: begin
            if (start_i) begin
               state_d = StIssue;
               idx_d   = '0;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign bus.req_valid_o   = (state_q == StIssue);
   assign bus.req_func_id_o = bus.req_valid_o ? slot_func_id_i[idx_q*FuncIdWidth +: FuncIdWidth]
                                              : '0;
   assign bus.req_arg_o     = bus.req_valid_o ? slot_arg_i[idx_q*ArgWidth +: ArgWidth] : '0;
   assign bus.rsp_ready_o   = (state_q == StWait);

   assign inj_valid_o = (state_q == StInject);
   assign inj_idx_o   = inj_idx_q;
   assign inj_data_o  = inj_data_q;

   assign busy_o     = (state_q == StIssue) || (state_q == StWait) ||
                       (state_q == StInject) || (state_q == StAdvance);
   assign done_o     = (state_q == StDone);
   assign dut_rst_no = (state_q == StDone);

`ifdef LOOM_INIT_DPI_TIMEOUT_EN
   assign error_o   = (state_q == StError);
   assign err_idx_o = (state_q == StError) ? idx_q : '0;
`else
   assign error_o   = 1'b0;
   assign err_idx_o = '0;
`endif

endmodule

// File: tb/tb_loom_init_dpi_seq.sv
// Directed self-checking bench for loom_init_dpi_seq with a simple zero-wait bridge model.
module tb_loom_init_dpi_seq;
   import loom_init_dpi_pkg::*;

   localparam int unsigned NumCalls = 2;
   localparam int unsigned FW       = 8;
   localparam int unsigned AW       = 32;
   localparam int unsigned RW       = 32;
   localparam int unsigned IdxW     = 1;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   logic start  = 1'b0;
   always #5 clk_i = ~clk_i;

   call_slot_t               slots [NumCalls];
   logic [NumCalls*FW-1:0]   slot_func_id;
   logic [NumCalls*AW-1:0]   slot_arg;

   logic        req_ready = 1'b0;
   logic        auto_rsp  = 1'b0;
   logic        force_rsp = 1'b0;
   logic [31:0] rsp_data  = 32'h1234_5678;

   logic            inj_valid;
   logic [IdxW-1:0] inj_idx;
   logic [RW-1:0]   inj_data;
   logic            dut_rst_n, busy, done, error;
   logic [IdxW-1:0] err_idx;

   loom_init_dpi_seq_if #(.FuncIdWidth(FW), .ArgWidth(AW), .RetWidth(RW)) bus ();

   // Bridge: answers in the first WAIT cycle when auto_rsp is set; force_rsp injects junk.
   assign bus.req_ready_i = req_ready;
   assign bus.rsp_valid_i = force_rsp | (auto_rsp & bus.rsp_ready_o);
   assign bus.rsp_data_i  = rsp_data;

   loom_init_dpi_seq #(
      .NumCalls      (NumCalls),
      .FuncIdWidth   (FW),
      .ArgWidth      (AW),
      .RetWidth      (RW),
      .VoidMask      (2'b01),
      .TimeoutCycles (16)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .start_i        (start),
      .slot_func_id_i (slot_func_id),
      .slot_arg_i     (slot_arg),
      .bus            (bus),
      .inj_valid_o    (inj_valid),
      .inj_idx_o      (inj_idx),
      .inj_data_o     (inj_data),
      .dut_rst_no     (dut_rst_n),
      .busy_o         (busy),
      .done_o         (done),
      .error_o        (error),
      .err_idx_o      (err_idx)
   );

   int total = 0;
   int bad   = 0;
   int accepts = 0;
   int injs    = 0;
   logic [IdxW-1:0] last_inj_idx  = '0;
   logic [RW-1:0]   last_inj_data = '0;

   always @(posedge clk_i) begin
      if (bus.req_valid_o && bus.req_ready_i) accepts <= accepts + 1;
      if (inj_valid) begin
         injs          <= injs + 1;
         last_inj_idx  <= inj_idx;
         last_inj_data <= inj_data;
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   function automatic logic [63:0] all_outs();
      return {32'(bus.req_arg_o), 8'(bus.req_func_id_o), bus.req_valid_o, bus.rsp_ready_o,
              inj_valid, inj_idx, 1'b0, dut_rst_n, busy, done, error, err_idx} |
             {32'h0, 32'(inj_data)};
   endfunction

   int   a0, i0;
   logic stable;

   initial begin
      slots[0] = '{func_id: 8'd3, arg: 32'd0};
      slots[1] = '{func_id: 8'd7, arg: 32'd42};
      for (int s = 0; s < NumCalls; s++) begin
         slot_func_id[s*FW +: FW] = slots[s].func_id;
         slot_arg[s*AW +: AW]     = slots[s].arg;
      end

      // Reset state
      rst_ni = 1'b0;
      repeat (3) tick();
      check_eq("reset_outs", all_outs(), 64'h0);
      rst_ni = 1'b1;
      tick();
      check_eq("idle_outs", all_outs(), 64'h0);

      // Full sequence with zero-wait bridge
      req_ready = 1'b1;
      auto_rsp  = 1'b1;
      pulse_start();
      check_eq("s0_req_valid", bus.req_valid_o, 1'b1);
      check_eq("s0_func_id", bus.req_func_id_o, 8'd3);
      check_eq("s0_arg", bus.req_arg_o, 32'd0);
      check_eq("s0_busy", busy, 1'b1);
      for (int i = 1; i <= 7; i++) begin
         tick();
         if (i == 3) begin
            check_eq("s1_func_id", bus.req_func_id_o, 8'd7);
            check_eq("s1_arg", bus.req_arg_o, 32'd42);
         end
         check_eq("seq_inj_valid", inj_valid, i == 5);
         check_eq("seq_done", done, i == 7);
         check_eq("seq_dut_rst_n", dut_rst_n, i == 7);
      end
      check_eq("seq_accepts", accepts, 2);
      check_eq("seq_inj_count", injs, 1);
      check_eq("seq_inj_idx", last_inj_idx, 1'b1);
      check_eq("seq_inj_data", last_inj_data, 32'h1234_5678);
      check_eq("inj_data_hold", inj_data, 32'h1234_5678);
      repeat (3) tick();
      check_eq("done_held", {done, dut_rst_n, busy}, 3'b110);

      // Restart from DONE with a stalled bridge and a spurious response
      req_ready = 1'b0;
      auto_rsp  = 1'b0;
      pulse_start();
      check_eq("restart_outs", {dut_rst_n, done, busy}, 3'b001);
      force_rsp = 1'b1;
      a0 = accepts;
      i0 = injs;
      stable = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (!(bus.req_valid_o && bus.req_func_id_o == 8'd3 && bus.req_arg_o == 32'd0 &&
               !bus.rsp_ready_o)) stable = 1'b0;
         tick();
      end
      check_eq("stall_stable", stable, 1'b1);
      force_rsp = 1'b0;
      req_ready = 1'b1;
      tick();
      check_eq("stall_accepts", accepts - a0, 1);
      check_eq("stall_in_wait", {bus.req_valid_o, bus.rsp_ready_o}, 2'b01);
      check_eq("spurious_no_inj", injs - i0, 0);
      auto_rsp = 1'b1;
      repeat (5) tick();
      check_eq("restart_not_done", done, 1'b0);
      tick();
      check_eq("restart_done", {done, dut_rst_n}, 2'b11);
      check_eq("restart_inj_count", injs - i0, 1);

      // Reset during WAIT of slot 1
      pulse_start();
      repeat (3) tick();
      check_eq("rst_s1_issue", bus.req_func_id_o, 8'd7);
      auto_rsp = 1'b0;
      tick();
      check_eq("rst_s1_wait", bus.rsp_ready_o, 1'b1);
      rst_ni = 1'b0;
      tick();
      check_eq("midrst_outs", all_outs(), 64'h0);
      rst_ni   = 1'b1;
      auto_rsp = 1'b1;
      pulse_start();
      check_eq("midrst_reissue", {bus.req_valid_o, bus.req_func_id_o}, {1'b1, 8'd3});
      repeat (7) tick();
      check_eq("midrst_done", {done, dut_rst_n}, 2'b11);

`ifdef LOOM_INIT_DPI_TIMEOUT_EN
      // Slot 1 never answers: error after 16 WAIT cycles
      pulse_start();
      repeat (3) tick();
      auto_rsp = 1'b0;
      tick();
      repeat (15) tick();
      check_eq("to_before", {error, busy}, 2'b01);
      tick();
      check_eq("to_error", {error, err_idx, busy, dut_rst_n, done}, 5'b11000);
      pulse_start();
      check_eq("to_restart", {error, busy}, 2'b01);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
